iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Multi-cycle, area-reduced counterpart to the single-cycle combinational shift unit. Used in the low-area core option.
- Implements RV32I SLL/SRL/SRA and shifts by at most STEP bits per clock.
- Operands are accepted through a valid/ready request port. The result is returned through a valid/ready response port, and it is held until the consumer takes it.

Parameters:
- XLEN, 32, datapath width.
- STEP, 4, maximum bits shifted per cycle; power of two, 1..XLEN.
- SHW (localparam), $clog2(XLEN), shift-amount width.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- In_Valid  input  1  request valid.
- In_Ready  output  1  request accepted when In_Valid and In_Ready are both high; equals (state==IDLE && !RST).
- Rs1  input  XLEN  operand to shift.
- Rs2  input  SHW  shift amount; only bits [SHW-1:0] are used.
- funct3_2  input  1  instruction funct3[2].
- funct7_5  input  1  instruction funct7[5].
- Out_Valid  output  1  result valid; high only in DONE.
- Out_Ready  input  1  consumer ready.
- Result  output  XLEN  shifted value.
- Busy  output  1  high in SHIFT or DONE.

Behaviour:
- Op encoding {funct7_5,funct3_2}: 00 SLL, 01 SRL (zero fill), 11 SRA (fill with Rs1[XLEN-1]), 10 illegal → Result 0.
- Reset (RST high at a CLK edge): state=IDLE, Result=0, remaining count=0, Out_Valid=0, Busy=0. In_Ready is 0 while RST is high. Reset aborts any in-flight operation, and the aborted operation produces no response.
- FSM IDLE:
  - On accept, latch Rs1, shift amount and op. Inputs are ignored after the accept edge.
  - If shift amount==0 or op is illegal, go to DONE with Result=Rs1 (or 0 for illegal).
  - Otherwise go to SHIFT with remaining=shift amount.
- FSM SHIFT:
  - Each cycle, shift the working value by s=min(remaining,STEP) using the latched op, and set remaining -= s.
  - When remaining reaches 0, go to DONE.
  - In_Valid is ignored.
- FSM DONE:
  - Out_Valid=1, and Result is held stable.
  - When Out_Ready=1, go to IDLE. Out_Valid drops on the next edge.
  - No new request is accepted in DONE. Minimum spacing between accepts is 2 cycles.
- Latency: accept at edge k → Out_Valid high after edge k+ceil(shamt/STEP). For shamt=0 or an illegal op, Out_Valid is high after edge k.
- SRA sign: the sign comes from the latched Rs1[XLEN-1] and is reapplied on every step. A multi-step SRA is bit-exact to a single >>>.
- Out_Ready while Out_Valid=0 is ignored. In_Valid while In_Ready=0 is ignored; the requester must hold the request.
- Result changes only on an IDLE→SHIFT/DONE transition or in SHIFT.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined: encoding 10 performs a rotate right by shamt, using the same stepping and the same latency formula.
- Undefined: encoding 10 is illegal and returns Result=0 with zero shift cycles.

Decomposition:
- Package shift_pkg holds: the op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_ROR=2'b10) and the FSM state encodings IDLE/SHIFT/DONE (2 bits).
- One sub-module, shift_step: combinational single step that shifts a value by 0..STEP under an op. It is instantiated once, in the SHIFT datapath.

Test Plan (STEP=4):
- SLL, Rs1=50, Rs2=4 → Result=800; Out_Valid high after edge k+1.
- SRL, Rs1=0xABCDFFFF, Rs2=5 → Result=0x055E6FFF; two SHIFT cycles.
- SRA, Rs1=0xABCDFFFF, Rs2=3 → Result=0xF579BFFF. Also SLL, Rs1=1, Rs2=31 → 0x80000000 after 8 SHIFT cycles.
- Rs2=0 with Rs1=0x1234 → 0x1234 after edge k. Op 10 without the macro → 0 after edge k. Op 10 with SHIFT_ROTATE_EN, Rs1=0x0000000F, Rs2=4 → 0xF0000000.
- Out_Ready held low 3 cycles in DONE → Result and Out_Valid stable, In_Ready=0, concurrent In_Valid not accepted. Release Out_Ready → IDLE, then the next request is accepted.
- RST pulsed mid-SHIFT on a Rs2=31 op → after the edge: Out_Valid=0, Result=0, Busy=0; In_Ready=1 once RST is low. A following SRL of 0x80000000 by 31 returns 0x00000001.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Op and FSM state encodings shared by the iterative shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational single step: shifts a value by 0..STEP bits.
//               Rotate-right path present only with SHIFT_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 6
) (
  input  shift_op_e         i_op,
  input  logic [XLEN-1:0]   i_val,
  input  logic              i_sign,
  input  logic [AW-1:0]     i_amt,
  output logic [XLEN-1:0]   o_val
);

  localparam logic [XLEN-1:0] C_ONES = {XLEN{1'b1}};

`ifdef SHIFT_ROTATE_EN
  logic [AW-1:0] w_lsh;
  assign w_lsh = AW'(XLEN) - i_amt;
`endif

  always_comb begin
    o_val = i_val;
    case (i_op)
      OP_SLL: o_val = i_val << i_amt;
      OP_SRL: o_val = i_val >> i_amt;
      // Vacated top bits are refilled from the latched sign, not the current MSB.
      OP_SRA: o_val = (i_val >> i_amt) | (~(C_ONES >> i_amt) & {XLEN{i_sign}});
`ifdef SHIFT_ROTATE_EN
      OP_ROR: o_val = (i_val >> i_amt) | (i_val << w_lsh);
`endif
      default: o_val = i_val;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iter_shift_unit.sv
// ============================================================================
// Module      : iter_shift_unit
// Description : Multi-cycle RV32I SLL/SRL/SRA unit, at most STEP bits/cycle,
//               valid/ready in and out. Macro SHIFT_ROTATE_EN enables ROR on op 10.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     In_Valid,
  output logic                     In_Ready,
  input  logic [XLEN-1:0]          Rs1,
  input  logic [$clog2(XLEN)-1:0]  Rs2,
  input  logic                     funct3_2,
  input  logic                     funct7_5,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic [XLEN-1:0]          Result,
  output logic                     Busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] c_step = (SHW+1)'(STEP);

  shift_state_e     r_state;
  shift_state_e     w_next;
  logic [XLEN-1:0]  r_result;
  logic [SHW-1:0]   r_rem;
  shift_op_e        r_op;
  logic             r_sign;

  shift_op_e        w_op;
  logic             w_illegal;
  logic             w_accept;
  logic [SHW:0]     w_rem_ext;
  logic [SHW:0]     w_amt;
  logic [XLEN-1:0]  w_step_val;

  assign w_op = shift_op_e'({funct7_5, funct3_2});

`ifdef SHIFT_ROTATE_EN
  assign w_illegal = 1'b0;
`else
  assign w_illegal = (w_op == OP_ROR);
`endif

  assign w_accept  = In_Valid && In_Ready;
  assign w_rem_ext = {1'b0, r_rem};
  assign w_amt     = (w_rem_ext > c_step) ? c_step : w_rem_ext;

  shift_step #(
    .XLEN (XLEN),
    .AW   (SHW + 1)
  ) u_step (
    .i_op   (r_op),
    .i_val  (r_result),
    .i_sign (r_sign),
    .i_amt  (w_amt),
    .o_val  (w_step_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    In_Ready  = 1'b0;
    Out_Valid = 1'b0;
    Busy      = 1'b0;
    case (r_state)
      IDLE: begin
        In_Ready = !RST;
        if (w_accept) w_next = ((Rs2 == '0) || w_illegal) ? DONE : SHIFT;
      end
      SHIFT: begin
        Busy = 1'b1;
        if (w_rem_ext == w_amt) w_next = DONE;
      end
      DONE: begin
        Busy      = 1'b1;
        Out_Valid = 1'b1;
        if (Out_Ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The result register doubles as the working value during SHIFT.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result <= '0;
      r_rem    <= '0;
      r_op     <= OP_SLL;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_result <= w_illegal ? '0 : Rs1;
            r_rem    <= w_illegal ? '0 : Rs2;
            r_op     <= w_op;
            r_sign   <= Rs1[XLEN-1];
          end
        end
        SHIFT: begin
          r_result <= w_step_val;
          r_rem    <= r_rem - w_amt[SHW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_iter_shift_unit.sv
// ============================================================================
// Module      : tb_iter_shift_unit
// Description : Directed self-checking bench for iter_shift_unit (STEP=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_shift_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [31:0] Rs1 = '0;
  logic [4:0]  Rs2 = '0;
  logic        funct3_2 = 1'b0;
  logic        funct7_5 = 1'b0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b0;
  logic [31:0] Result;
  logic        Busy;

  int nchecks = 0;
  int nerrors = 0;

  iter_shift_unit #(.XLEN(32), .STEP(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .funct3_2  (funct3_2),
    .funct7_5  (funct7_5),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request and returns #1 after the accept edge.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [4:0] b,
                        input logic f7, input logic f3);
    @(negedge CLK);
    In_Valid = 1'b1; Rs1 = a; Rs2 = b; funct7_5 = f7; funct3_2 = f3;
    chk({tag, " in_ready"}, {31'b0, In_Ready}, 32'd1);
    @(posedge CLK); #1;
    In_Valid = 1'b0; Rs1 = 32'hFFFF_FFFF; Rs2 = 5'd17;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp, input int lat_exp);
    int lat = 0;
    while (Out_Valid !== 1'b1 && lat < 64) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
    chk({tag, " result"}, Result, exp);
  endtask

  task automatic release_out(input string tag);
    @(negedge CLK);
    Out_Ready = 1'b1;
    @(posedge CLK); #1;
    Out_Ready = 1'b0;
    chk({tag, " ov_drop"}, {31'b0, Out_Valid}, 32'd0);
    chk({tag, " busy_drop"}, {31'b0, Busy}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [4:0] b,
                     input logic f7, input logic f3, input logic [31:0] exp, input int lat);
    do_req(tag, a, b, f7, f3);
    wait_done(tag, exp, lat);
    release_out(tag);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst result", Result, 32'd0);
    chk("rst out_valid", {31'b0, Out_Valid}, 32'd0);
    chk("rst busy", {31'b0, Busy}, 32'd0);
    chk("rst in_ready", {31'b0, In_Ready}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst in_ready", {31'b0, In_Ready}, 32'd1);

    run("sll50_4",   32'd50,        5'd4,  1'b0, 1'b0, 32'd800,      1);
    run("srl_5",     32'hABCD_FFFF, 5'd5,  1'b0, 1'b1, 32'h055E_6FFF, 2);
    run("sra_3",     32'hABCD_FFFF, 5'd3,  1'b1, 1'b1, 32'hF579_BFFF, 1);
    run("sra_6",     32'h8000_0000, 5'd6,  1'b1, 1'b1, 32'hFE00_0000, 2);
    run("sra_31",    32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 8);
    run("sll1_31",   32'd1,         5'd31, 1'b0, 1'b0, 32'h8000_0000, 8);
    run("zero_amt",  32'h0000_1234, 5'd0,  1'b0, 1'b1, 32'h0000_1234, 0);
`ifdef SHIFT_ROTATE_EN
    run("ror_4",     32'h0000_000F, 5'd4,  1'b1, 1'b0, 32'hF000_0000, 1);
`else
    run("op10",      32'h0000_000F, 5'd4,  1'b1, 1'b0, 32'd0,        0);
`endif

    // Hold the result in DONE while a competing request is presented.
    do_req("hold", 32'd3, 5'd2, 1'b0, 1'b0);
    wait_done("hold", 32'd12, 1);
    @(negedge CLK);
    In_Valid = 1'b1; Rs1 = 32'h0000_DEAD; Rs2 = 5'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("hold out_valid", {31'b0, Out_Valid}, 32'd1);
      chk("hold result", Result, 32'd12);
      chk("hold in_ready", {31'b0, In_Ready}, 32'd0);
    end
    @(negedge CLK);
    In_Valid = 1'b0;
    release_out("hold");
    run("after_hold", 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_000F, 1);

    // Reset in the middle of a long shift must discard the operation.
    do_req("abort", 32'd1, 5'd31, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort out_valid", {31'b0, Out_Valid}, 32'd0);
    chk("abort result", Result, 32'd0);
    chk("abort busy", {31'b0, Busy}, 32'd0);
    chk("abort in_ready_rst", {31'b0, In_Ready}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort in_ready", {31'b0, In_Ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("abort no_resp", {30'b0, Out_Valid, Busy}, 32'd0);
    end
    run("srl_31", 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'h0000_0001, 8);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

`default_nettype wire
